uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits.
// The frame format is latched at acceptance, so later input changes only affect the next frame.
module uart_tx_cfg #(
  parameter int CLK_RATE  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int CLK_DIV   = CLK_RATE / BAUD_RATE,
  parameter int CNT_W     = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_din,
  input  logic [1:0] cfg_len,
  input  logic [1:0] cfg_par,
  input  logic       cfg_stop2,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_END  = CNT_W'(CLK_DIV - 2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       lat_data;
  logic [1:0]       lat_len;
  logic [1:0]       lat_par;
  logic             lat_stop2;

  logic             bit_end;
  logic             last_data;
  logic             frame_end;
  logic [2:0]       nxt_idx;

  function automatic logic [7:0] data_mask(input logic [1:0] len);
    logic [7:0] m;
    case (len)
      2'b00:   m = 8'h1F;
      2'b01:   m = 8'h3F;
      2'b10:   m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic par_enabled(input logic [1:0] par);
    return (par == 2'b01) || (par == 2'b10);
  endfunction

  // Even parity is the XOR of the transmitted bits only; odd is its inverse.
  function automatic logic par_bit(input logic [7:0] data, input logic [1:0] len,
                                   input logic [1:0] par);
    return (^(data & data_mask(len))) ^ (par == 2'b10);
  endfunction

  assign tx_ready  = (state == S_IDLE);
  assign bit_end   = (cnt == DIV_LAST);
  assign last_data = (bit_idx == {1'b1, lat_len});
  assign nxt_idx   = bit_idx + 3'd1;
  // The final stop period ends one cycle early in-state: its last cycle is the
  // IDLE/done cycle, letting a back-to-back start bit follow with no gap.
  assign frame_end = (state == S_STOP) && (bit_idx[0] == lat_stop2) && (cnt == DIV_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      lat_data  <= '0;
      lat_len   <= '0;
      lat_par   <= '0;
      lat_stop2 <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx      <= 1'b1;
          cnt     <= '0;
          bit_idx <= '0;
          if (tx_valid) begin
            lat_data  <= tx_din;
            lat_len   <= cfg_len;
            lat_par   <= cfg_par;
            lat_stop2 <= cfg_stop2;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            cnt   <= '0;
            tx    <= lat_data[0];
            state <= S_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (last_data) begin
              bit_idx <= '0;
              if (par_enabled(lat_par)) begin
                tx    <= par_bit(lat_data, lat_len, lat_par);
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= nxt_idx;
              tx      <= lat_data[nxt_idx];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          tx <= 1'b1;
          if (frame_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            state   <= S_IDLE;
          end else if (bit_end) begin
            cnt     <= '0;
            bit_idx <= 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= S_IDLE;
          cnt     <= '0;
          bit_idx <= '0;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg with CLK_DIV=4; outputs sampled on the falling edge.
// Cycle k=1 is the first cycle after the accepting rising edge.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_din = 8'h00;
  logic [1:0] cfg_len = 2'b11;
  logic [1:0] cfg_par = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int tests = 0;
  int failed = 0;

  logic tx_a   [0:127];
  logic busy_a [0:127];
  logic done_a [0:127];
  logic rdy_a  [0:127];
  int   exp_q[$];

  uart_tx_cfg #(
    .CLK_RATE (400),
    .BAUD_RATE(100),
    .CLK_DIV  (4),
    .CNT_W    (17)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_din   (tx_din),
    .cfg_len  (cfg_len),
    .cfg_par  (cfg_par),
    .cfg_stop2(cfg_stop2),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] d, input logic [1:0] l, input logic [1:0] p,
                      input logic s, input logic hold);
    int t = 0;
    @(negedge clk);
    tx_din = d; cfg_len = l; cfg_par = p; cfg_stop2 = s; tx_valid = 1'b1;
    while (!tx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) begin
      tests++; failed++;
      $display("FAIL send_ready: tx_ready=%b after %0d cycles, required 1", tx_ready, t);
    end
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tx_a[k] = tx; busy_a[k] = tx_busy; done_a[k] = tx_done; rdy_a[k] = tx_ready;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      failed++;
      $display("FAIL reset_outputs: tx/busy/done=%b%b%b, required 100", tx, tx_busy, tx_done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (tx_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset_ready: tx_ready=%b, required 1", tx_ready);
    end
    capture(6);
    tests++;
    begin
      int bad = 0;
      for (int k = 1; k <= 6; k++)
        if (tx_a[k] !== 1'b1 || busy_a[k] !== 1'b0 || done_a[k] !== 1'b0) bad++;
      if (bad != 0) begin
        failed++;
        $display("FAIL idle_line: %0d idle cycles not tx=1/busy=0/done=0, required 0", bad);
      end
    end
  endtask

  task automatic test_8n1;
    send(8'hA5, 2'b11, 2'b00, 1'b0, 1'b0);
    capture(41);
    exp_q = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    for (int b = 0; b < exp_q.size(); b++) begin
      tests++;
      if ({tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4]} !== {4{exp_q[b][0]}}) begin
        failed++;
        $display("FAIL 8n1_bit%0d: got %b%b%b%b, required 4x%0d", b,
                 tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4], exp_q[b]);
      end
    end
    tests++;
    begin
      int bad = 0;
      for (int k = 1; k <= 41; k++)
        if (done_a[k] !== (k == 40) || busy_a[k] !== (k < 40)) bad++;
      if (bad != 0) begin
        failed++;
        $display("FAIL 8n1_done_busy: %0d cycles wrong, required done only at 40, busy 1..39", bad);
      end
    end
    tests++;
    if (rdy_a[40] !== 1'b1 || rdy_a[39] !== 1'b0) begin
      failed++;
      $display("FAIL 8n1_ready: ready@39=%b ready@40=%b, required 0 and 1", rdy_a[39], rdy_a[40]);
    end
  endtask

  task automatic test_7e2;
    send(8'h3C, 2'b10, 2'b01, 1'b1, 1'b0);
    capture(45);
    exp_q = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    for (int b = 0; b < exp_q.size(); b++) begin
      tests++;
      if ({tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4]} !== {4{exp_q[b][0]}}) begin
        failed++;
        $display("FAIL 7e2_bit%0d: got %b%b%b%b, required 4x%0d", b,
                 tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4], exp_q[b]);
      end
    end
    tests++;
    begin
      int bad = 0;
      for (int k = 1; k <= 45; k++) if (done_a[k] !== (k == 44)) bad++;
      if (bad != 0) begin
        failed++;
        $display("FAIL 7e2_done: %0d cycles wrong, required single pulse at 44", bad);
      end
    end
  endtask

  task automatic test_5o1;
    send(8'hFF, 2'b00, 2'b10, 1'b0, 1'b0);
    capture(33);
    exp_q = '{0, 1, 1, 1, 1, 1, 0, 1};
    for (int b = 0; b < exp_q.size(); b++) begin
      tests++;
      if ({tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4]} !== {4{exp_q[b][0]}}) begin
        failed++;
        $display("FAIL 5o1_bit%0d: got %b%b%b%b, required 4x%0d", b,
                 tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4], exp_q[b]);
      end
    end
    tests++;
    begin
      int bad = 0;
      for (int k = 1; k <= 33; k++) if (done_a[k] !== (k == 32)) bad++;
      if (bad != 0) begin
        failed++;
        $display("FAIL 5o1_done: %0d cycles wrong, required single pulse at 32", bad);
      end
    end
  endtask

  task automatic test_back_to_back;
    send(8'h55, 2'b11, 2'b00, 1'b0, 1'b1);
    for (int k = 1; k <= 81; k++) begin
      @(negedge clk);
      tx_a[k] = tx; busy_a[k] = tx_busy; done_a[k] = tx_done; rdy_a[k] = tx_ready;
      if (k == 1) tx_din = 8'h0F;
      if (k == 41) tx_valid = 1'b0;
    end
    exp_q = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1,
              0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    for (int b = 0; b < exp_q.size(); b++) begin
      tests++;
      if ({tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4]} !== {4{exp_q[b][0]}}) begin
        failed++;
        $display("FAIL b2b_bit%0d: got %b%b%b%b, required 4x%0d", b,
                 tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4], exp_q[b]);
      end
    end
    tests++;
    begin
      int bad = 0;
      for (int k = 1; k <= 81; k++) if (done_a[k] !== (k == 40 || k == 80)) bad++;
      if (bad != 0) begin
        failed++;
        $display("FAIL b2b_done: %0d cycles wrong, required pulses at 40 and 80", bad);
      end
    end
    tests++;
    if (busy_a[41] !== 1'b1 || rdy_a[41] !== 1'b0) begin
      failed++;
      $display("FAIL b2b_second_accept: busy@41=%b ready@41=%b, required 1 and 0",
               busy_a[41], rdy_a[41]);
    end
  endtask

  task automatic test_reset_mid_frame;
    send(8'h00, 2'b11, 2'b00, 1'b0, 1'b0);
    capture(17);
    tests++;
    if (tx_a[17] !== 1'b0 || busy_a[17] !== 1'b1) begin
      failed++;
      $display("FAIL rst_mid_pre: tx=%b busy=%b in data bit 3, required 0 and 1",
               tx_a[17], busy_a[17]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      failed++;
      $display("FAIL rst_mid_async: tx/busy/done=%b%b%b, required 100", tx, tx_busy, tx_done);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    capture(4);
    tests++;
    begin
      int bad = 0;
      for (int k = 1; k <= 4; k++)
        if (done_a[k] !== 1'b0 || rdy_a[k] !== 1'b1 || tx_a[k] !== 1'b1) bad++;
      if (bad != 0) begin
        failed++;
        $display("FAIL rst_mid_after: %0d cycles not idle/ready without done, required 0", bad);
      end
    end
    send(8'h81, 2'b11, 2'b00, 1'b0, 1'b0);
    capture(41);
    exp_q = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
    for (int b = 0; b < exp_q.size(); b++) begin
      tests++;
      if ({tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4]} !== {4{exp_q[b][0]}}) begin
        failed++;
        $display("FAIL rst_frame_bit%0d: got %b%b%b%b, required 4x%0d", b,
                 tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4], exp_q[b]);
      end
    end
    tests++;
    if (done_a[40] !== 1'b1 || done_a[39] !== 1'b0) begin
      failed++;
      $display("FAIL rst_frame_done: done@39=%b done@40=%b, required 0 and 1",
               done_a[39], done_a[40]);
    end
  endtask

  task automatic test_cfg_change;
    send(8'hC3, 2'b11, 2'b00, 1'b0, 1'b0);
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      tx_a[k] = tx; busy_a[k] = tx_busy; done_a[k] = tx_done; rdy_a[k] = tx_ready;
      if (k == 1) begin
        cfg_len = 2'b00; cfg_par = 2'b01; cfg_stop2 = 1'b1; tx_din = 8'h00;
      end
    end
    exp_q = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 1};
    for (int b = 0; b < exp_q.size(); b++) begin
      tests++;
      if ({tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4]} !== {4{exp_q[b][0]}}) begin
        failed++;
        $display("FAIL cfg_old_bit%0d: got %b%b%b%b, required 4x%0d", b,
                 tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4], exp_q[b]);
      end
    end
    tests++;
    if (done_a[40] !== 1'b1 || busy_a[39] !== 1'b1) begin
      failed++;
      $display("FAIL cfg_old_len: done@40=%b busy@39=%b, required 1 and 1", done_a[40], busy_a[39]);
    end
    send(8'hC3, 2'b00, 2'b01, 1'b1, 1'b0);
    capture(37);
    exp_q = '{0, 1, 1, 0, 0, 0, 0, 1, 1};
    for (int b = 0; b < exp_q.size(); b++) begin
      tests++;
      if ({tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4]} !== {4{exp_q[b][0]}}) begin
        failed++;
        $display("FAIL cfg_new_bit%0d: got %b%b%b%b, required 4x%0d", b,
                 tx_a[b*4+1], tx_a[b*4+2], tx_a[b*4+3], tx_a[b*4+4], exp_q[b]);
      end
    end
    tests++;
    begin
      int bad = 0;
      for (int k = 1; k <= 37; k++) if (done_a[k] !== (k == 36)) bad++;
      if (bad != 0) begin
        failed++;
        $display("FAIL cfg_new_done: %0d cycles wrong, required single pulse at 36", bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1();
    test_back_to_back();
    test_reset_mid_frame();
    test_cfg_change();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
